// File: rtl/mc_loader_pkg.sv
// Shared types and default geometry for the MC program loader and the MC imem it feeds.
package mc_loader_pkg;

  localparam int DEF_ADDR_W         = 4;
  localparam int DEF_DEPTH          = 16;
  localparam int DEF_INSTR_W        = 31;
  localparam int DEF_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/mc_byte_assembler.sv
// Little-endian byte shift-in register with byte counter and running XOR checksum.
module mc_byte_assembler #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        shift_en,
  input  logic [7:0]                  in_data,
  output logic [BYTES_PER_WORD*8-1:0] word_next,
  output logic [7:0]                  xor_sum,
  output logic                        word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [BYTES_PER_WORD*8-1:0] asm_r;
  logic [CNT_W-1:0]            byte_cnt_r;
  logic [7:0]                  xor_r;

  // Current byte merged into its lane so a completed word is visible before it is registered.
  always_comb begin
    word_next = asm_r;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (byte_cnt_r == CNT_W'(i)) begin
        word_next[8*i +: 8] = in_data;
      end else begin
        word_next[8*i +: 8] = asm_r[8*i +: 8];
      end
    end
  end

  assign word_full = shift_en && (byte_cnt_r == LAST_IDX);
  assign xor_sum   = xor_r;

  // Shift-in register, byte counter and checksum accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_r      <= '0;
      byte_cnt_r <= '0;
      xor_r      <= 8'h00;
    end else if (clear) begin
      asm_r      <= '0;
      byte_cnt_r <= '0;
      xor_r      <= 8'h00;
    end else if (shift_en) begin
      asm_r      <= word_next;
      xor_r      <= xor_r ^ in_data;
      byte_cnt_r <= word_full ? '0 : byte_cnt_r + CNT_ONE;
    end else begin
      asm_r      <= asm_r;
      byte_cnt_r <= byte_cnt_r;
      xor_r      <= xor_r;
    end
  end

endmodule

// File: rtl/mc_program_loader.sv
// Loads a LEN/DATA/CHK byte frame into the MC imem, holding the MC core frozen until
// the whole image and its checksum have been accepted.
module mc_program_loader
  import mc_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int INSTR_W        = DEF_INSTR_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               mc_hold,
  output logic               mc_restart,
  output logic               done,
  output logic               error
);

  localparam int WORD_W = BYTES_PER_WORD * 8;
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [8:0]      DEPTH_LIM = 9'(DEPTH);

  state_t               state_r;
  logic                 in_ready_r, mem_we_r, mc_hold_r, mc_restart_r, done_r, error_r;
  logic                 bad_word_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [INSTR_W-1:0]   mem_wdata_r;
  logic [ADDR_W:0]      word_cnt_r, n_r;
  logic                 xfer_s, clear_s, shift_s, word_full_s, upper_bad_s;
  logic [WORD_W-1:0]    word_next_s;
  logic [7:0]           xor_s;

  assign xfer_s      = in_valid && in_ready_r;
  assign upper_bad_s = |word_next_s[WORD_W-1:INSTR_W];

  // start only (re)opens a frame from idle or a finished load; mid-frame it is dropped.
  always_comb begin
    clear_s = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      IDLE, DONE, ERR: clear_s = start;
      DATA:            shift_s = xfer_s;
      default: begin
        clear_s = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  mc_byte_assembler #(
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .shift_en  (shift_s),
    .in_data   (in_data),
    .word_next (word_next_s),
    .xor_sum   (xor_s),
    .word_full (word_full_s)
  );

  // Frame FSM with registered handshake, imem write port and MC control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mc_hold_r    <= 1'b0;
      mc_restart_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      bad_word_r   <= 1'b0;
      word_cnt_r   <= '0;
      n_r          <= '0;
    end else begin
      mem_we_r     <= 1'b0;
      mc_restart_r <= 1'b0;
      if (clear_s) begin
        state_r    <= LEN;
        in_ready_r <= 1'b1;
        mc_hold_r  <= 1'b1;
        done_r     <= 1'b0;
        error_r    <= 1'b0;
        word_cnt_r <= '0;
      end else begin
        case (state_r)
          LEN: begin
            if (xfer_s) begin
              if ((in_data == 8'd0) || ({1'b0, in_data} > DEPTH_LIM)) begin
                state_r    <= ERR;
                in_ready_r <= 1'b0;
                error_r    <= 1'b1;
              end else begin
                n_r     <= in_data[ADDR_W:0];
                state_r <= DATA;
              end
            end
          end
          DATA: begin
            // The write is issued on the edge that takes the last byte, so mem_we lands in WRITE.
            if (word_full_s) begin
              state_r    <= WRITE;
              in_ready_r <= 1'b0;
              bad_word_r <= upper_bad_s;
              if (!upper_bad_s) begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
                mem_wdata_r <= word_next_s[INSTR_W-1:0];
              end
            end
          end
          WRITE: begin
            if (bad_word_r) begin
              state_r <= ERR;
              error_r <= 1'b1;
            end else if ((word_cnt_r + CNT_ONE) == n_r) begin
              state_r    <= CHK;
              in_ready_r <= 1'b1;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_ONE;
              state_r    <= DATA;
              in_ready_r <= 1'b1;
            end
          end
          CHK: begin
            if (xfer_s) begin
              in_ready_r <= 1'b0;
              if (in_data == xor_s) begin
                state_r      <= DONE;
                done_r       <= 1'b1;
                mc_hold_r    <= 1'b0;
                mc_restart_r <= 1'b1;
              end else begin
                state_r <= ERR;
                error_r <= 1'b1;
              end
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mc_hold    = mc_hold_r;
  assign mc_restart = mc_restart_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
